fan_tick_gen: RTL and testbench

Produces the angular tick stream (`fanclk`) consumed by the LED-fan pattern blocks. It measures the revolution period from a once-per-revolution hall-sensor pulse and emits exactly `TICKS` single-cycle pulses per revolution, phase-aligned to the index. The pulses are evenly spread using a Bresenham accumulator, so no divider is needed. It sits between the sensor pin and every pattern block that decrements a degree counter on `fanclk`.

---
 rtl/fan_pkg.sv | 16 +
 rtl/fan_hall_sync.sv | 69 ++++++
 rtl/fan_tick_gen.sv | 144 ++++++++++++++
 tb/tb_fan_tick_gen.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fan_pkg.sv
// Shared types and default parameters for the fan tick generator.
// The optional debounce filter is enabled with FAN_TICK_DEBOUNCE_EN.
package fan_pkg;

  localparam int unsigned TICKS_DEF      = 360;
  localparam int unsigned PERIOD_W_DEF   = 24;
  localparam int unsigned MIN_PERIOD_DEF = 3600;
  localparam int unsigned DEB_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } fan_state_e;

endpackage

// File: rtl/fan_hall_sync.sv
// Hall input conditioning: 2-flop synchronizer, optional debounce filter
// (FAN_TICK_DEBOUNCE_EN) and registered falling-edge detect.
module fan_hall_sync
  import fan_pkg::*;
#(
`ifdef FAN_TICK_DEBOUNCE_EN
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic hall_i,
  output logic hall_fall_o
);

  logic s1_q, s2_q;
  logic filt;
  logic prev_q, fall_q;

  // Flops clear to 0 so a line held low across reset release gives no edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= hall_i;
      s2_q <= s1_q;
    end
  end

`ifdef FAN_TICK_DEBOUNCE_EN
  localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_RELOAD = DW'(DEB_CYCLES - 1);

  logic [DW-1:0] deb_q;
  logic          filt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q  <= DEB_RELOAD;
      filt_q <= 1'b0;
    end else if (s2_q == filt_q) begin
      deb_q <= DEB_RELOAD;
    end else if (deb_q == '0) begin
      filt_q <= s2_q;
      deb_q  <= DEB_RELOAD;
    end else begin
      deb_q <= deb_q - DW'(1);
    end
  end

  assign filt = filt_q;
`else
  assign filt = s2_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      prev_q <= filt;
      fall_q <= prev_q & ~filt;
    end
  end

  assign hall_fall_o = fall_q;

endmodule

// File: rtl/fan_tick_gen.sv
// Revolution period measurement and Bresenham-spread angular tick stream.
// FAN_TICK_DEBOUNCE_EN adds a DEB_CYCLES stability filter on hall_in.
//
// state      | meaning
// IDLE       | no reference, waiting for a first index
// MEASURE    | one index seen, timing the first full revolution
// LOCKED     | period known, emitting TICKS pulses per revolution
module fan_tick_gen
  import fan_pkg::*;
#(
  parameter int unsigned TICKS      = TICKS_DEF,
  parameter int unsigned PERIOD_W   = PERIOD_W_DEF,
  parameter int unsigned MIN_PERIOD = MIN_PERIOD_DEF,
  parameter int unsigned MAX_PERIOD = (1 << PERIOD_W) - 1
`ifdef FAN_TICK_DEBOUNCE_EN
  , parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hall_in,
  output logic                fanclk,
  output logic                index,
  output logic                locked,
  output logic                slip,
  output logic [PERIOD_W-1:0] period
);

  localparam int unsigned AW     = PERIOD_W + 1;
  localparam int unsigned TCNT_W = $clog2(TICKS);

  localparam logic [PERIOD_W-1:0] MIN_C = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] MAX_C = PERIOD_W'(MAX_PERIOD);
  localparam logic [AW-1:0]       TICKS_A = AW'(TICKS);
  localparam logic [TCNT_W-1:0]   TLAST = TCNT_W'(TICKS - 1);

  logic hall_fall;

  fan_hall_sync
`ifdef FAN_TICK_DEBOUNCE_EN
    #(.DEB_CYCLES(DEB_CYCLES))
`endif
    u_sync (
      .clk        (clk),
      .rst        (rst),
      .hall_i     (hall_in),
      .hall_fall_o(hall_fall)
    );

  fan_state_e          state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [AW-1:0]       acc_q, acc_d, acc_sum;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                fanclk_q, fanclk_d;
  logic                index_q, index_d;
  logic                slip_q, slip_d;
  logic                locked_q;
  logic                accept, timeout;

  assign acc_sum = acc_q + TICKS_A;
  assign accept  = hall_fall && ((state_q == ST_IDLE) || (cnt_q >= MIN_C));
  assign timeout = (state_q != ST_IDLE) && (cnt_q == MAX_C);

  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q == MAX_C) ? cnt_q : cnt_q + PERIOD_W'(1);
    period_d = period_q;
    acc_d    = acc_q;
    tcnt_d   = tcnt_q;
    fanclk_d = 1'b0;
    index_d  = 1'b0;
    slip_d   = 1'b0;

    if (timeout) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      tcnt_d  = '0;
    end else if (accept) begin
      index_d = 1'b1;
      // The accept cycle counts as cycle 0, so cnt equals the index spacing.
      cnt_d   = PERIOD_W'(1);
      unique case (state_q)
        ST_IDLE: state_d = ST_MEASURE;
        ST_MEASURE: begin
          period_d = cnt_q;
          acc_d    = '0;
          tcnt_d   = '0;
          fanclk_d = 1'b1;
          state_d  = ST_LOCKED;
        end
        default: begin
          fanclk_d = 1'b1;
          slip_d   = (tcnt_q < TLAST);
          period_d = cnt_q;
          acc_d    = '0;
          tcnt_d   = '0;
        end
      endcase
    end else if (state_q == ST_LOCKED) begin
      if (acc_sum >= {1'b0, period_q}) begin
        acc_d = acc_sum - {1'b0, period_q};
        // Past TICKS-1 pulses the fan is late; the index supplies the last tick.
        if (tcnt_q < TLAST) begin
          fanclk_d = 1'b1;
          tcnt_d   = tcnt_q + TCNT_W'(1);
        end
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      acc_q    <= '0;
      tcnt_q   <= '0;
      fanclk_q <= 1'b0;
      index_q  <= 1'b0;
      slip_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      acc_q    <= acc_d;
      tcnt_q   <= tcnt_d;
      fanclk_q <= fanclk_d;
      index_q  <= index_d;
      slip_q   <= slip_d;
      locked_q <= (state_q == ST_LOCKED);
    end
  end

  assign fanclk = fanclk_q;
  assign index  = index_q;
  assign slip   = slip_q;
  assign locked = locked_q;
  assign period = period_q;

endmodule

// File: tb/tb_fan_tick_gen.sv
// Scoreboard bench for fan_tick_gen: randomized hall schedules, expected pulse
// times derived from the ceil(k*P/TICKS) placement rule, checked by a monitor.
module tb_fan_tick_gen;

  localparam int T    = 360;
  localparam int MINP = 3600;
  localparam int MAXP = 10000;
`ifdef FAN_TICK_DEBOUNCE_EN
  localparam int DEB     = 16;
  localparam int LAT     = 4 + DEB;
  localparam int LOW_MIN = DEB + 4;
`else
  localparam int DEB     = 1;
  localparam int LAT     = 4;
  localparam int LOW_MIN = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        hall_in;
  logic        fanclk, index, locked, slip;
  logic [23:0] period;

  fan_tick_gen #(.MAX_PERIOD(MAXP)) dut (
    .clk    (clk),
    .rst    (rst),
    .hall_in(hall_in),
    .fanclk (fanclk),
    .index  (index),
    .locked (locked),
    .slip   (slip),
    .period (period)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int q_fan[$], q_idx[$], q_per[$], q_slip[$], q_lk_t[$];
  bit q_lk_v[$];
  int ev_t[$], ev_w[$];
  int lim;
  int tests = 0, fails = 0;
  int zero_req = 0, zero_seen = 0, drain_req = 0, drain_seen = 0;

  function automatic void push_fan(int t);
    if (t <= lim) q_fan.push_back(t);
  endfunction

  function automatic void push_idx(int t, int p);
    if (t <= lim) begin
      q_idx.push_back(t);
      q_per.push_back(p);
    end
  endfunction

  function automatic void push_slip(int t);
    if (t <= lim) q_slip.push_back(t);
  endfunction

  function automatic void push_lk(int t, bit v);
    if (t <= lim) begin
      q_lk_t.push_back(t);
      q_lk_v.push_back(v);
    end
  endfunction

  // Ticks of one revolution starting at 'start' with period p, strictly before 'stop'.
  function automatic int emit(int start, int p, int stop);
    int n = 0;
    for (int k = 1; k < T; k++) begin
      int j = (k * p + T - 1) / T;
      if (start + j >= stop) break;
      push_fan(start + j);
      n++;
    end
    return n;
  endfunction

  // Reference model over the hall schedule; times are monitor cycle numbers.
  function automatic void model();
    int st = 0, last = 0, per = 0, cur = 0, n, a;
    for (int i = 0; i < ev_t.size(); i++) begin
      if (ev_w[i] < DEB) continue;
      a = ev_t[i] + LAT;
      if (st != 0 && a - last > MAXP) begin
        if (st == 2) begin
          void'(emit(last, per, last + MAXP));
          push_lk(last + MAXP + 1, 1'b0);
        end
        st = 0;
      end
      if (st != 0 && a - last < MINP) continue;
      case (st)
        0: begin
          push_idx(a, cur);
          st = 1;
        end
        1: begin
          cur = a - last;
          per = cur;
          push_fan(a);
          push_idx(a, cur);
          push_lk(a + 1, 1'b1);
          st = 2;
        end
        default: begin
          n = emit(last, per, a);
          push_fan(a);
          if (n < T - 1) push_slip(a);
          cur = a - last;
          per = cur;
          push_idx(a, cur);
        end
      endcase
      last = a;
    end
    if (st == 2) begin
      void'(emit(last, per, last + MAXP));
      push_lk(last + MAXP + 1, 1'b0);
    end
  endfunction

  function automatic void clear_all();
    q_fan.delete(); q_idx.delete(); q_per.delete(); q_slip.delete();
    q_lk_t.delete(); q_lk_v.delete();
    ev_t.delete(); ev_w.delete();
  endfunction

  function automatic void add_ev(int t, int w);
    ev_t.push_back(t);
    ev_w.push_back(w);
  endfunction

  function automatic int real_w();
    return $urandom_range(LOW_MIN + 12, LOW_MIN);
  endfunction

  function automatic int glitch_w();
`ifdef FAN_TICK_DEBOUNCE_EN
    return 5;
`else
    return $urandom_range(8, 2);
`endif
  endfunction

  task automatic drive(input int stop_before);
    for (int i = 0; i < ev_t.size(); i++) begin
      if (ev_t[i] >= stop_before) break;
      while (cyc < ev_t[i]) @(negedge clk);
      hall_in = 1'b0;
      repeat (ev_w[i]) @(negedge clk);
      hall_in = 1'b1;
    end
  endtask

  // Monitor: sole owner of the comparison counters.
  int  exp_t, exp_p;
  bit  exp_v;
  bit  lk_prev = 1'b0;
  always @(negedge clk) begin
    if (fanclk) begin
      tests++;
      if (q_fan.size() == 0) begin
        fails++; $display("FAIL fanclk: pulse at cycle %0d, none expected", cyc);
      end else begin
        exp_t = q_fan.pop_front();
        if (exp_t != cyc) begin
          fails++; $display("FAIL fanclk: pulse at cycle %0d, expected cycle %0d", cyc, exp_t);
        end
      end
    end
    if (index) begin
      tests++;
      if (q_idx.size() == 0) begin
        fails++; $display("FAIL index: pulse at cycle %0d, none expected", cyc);
      end else begin
        exp_t = q_idx.pop_front();
        exp_p = q_per.pop_front();
        if (exp_t != cyc || exp_p != int'(period)) begin
          fails++;
          $display("FAIL index: cycle %0d period %0d, expected cycle %0d period %0d",
                   cyc, period, exp_t, exp_p);
        end
      end
    end
    if (slip) begin
      tests++;
      if (q_slip.size() == 0) begin
        fails++; $display("FAIL slip: pulse at cycle %0d, none expected", cyc);
      end else begin
        exp_t = q_slip.pop_front();
        if (exp_t != cyc) begin
          fails++; $display("FAIL slip: pulse at cycle %0d, expected cycle %0d", cyc, exp_t);
        end
      end
    end
    if (locked != lk_prev) begin
      tests++;
      if (q_lk_t.size() == 0) begin
        fails++; $display("FAIL locked: changed to %0b at cycle %0d, no change expected", locked, cyc);
      end else begin
        exp_t = q_lk_t.pop_front();
        exp_v = q_lk_v.pop_front();
        if (exp_t != cyc || exp_v != locked) begin
          fails++;
          $display("FAIL locked: became %0b at cycle %0d, expected %0b at cycle %0d",
                   locked, cyc, exp_v, exp_t);
        end
      end
      lk_prev = locked;
    end
    if (zero_req != zero_seen) begin
      zero_seen = zero_req;
      tests += 5;
      if (fanclk !== 1'b0) begin fails++; $display("FAIL reset_fanclk: got %b, expected 0", fanclk); end
      if (index  !== 1'b0) begin fails++; $display("FAIL reset_index: got %b, expected 0", index); end
      if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b, expected 0", locked); end
      if (slip   !== 1'b0) begin fails++; $display("FAIL reset_slip: got %b, expected 0", slip); end
      if (period !== 24'd0) begin fails++; $display("FAIL reset_period: got %0d, expected 0", period); end
    end
    if (drain_req != drain_seen) begin
      drain_seen = drain_req;
      tests += 4;
      if (q_fan.size() != 0) begin fails++; $display("FAIL drain_fanclk: %0d pulses missing, expected 0", q_fan.size()); end
      if (q_idx.size() != 0) begin fails++; $display("FAIL drain_index: %0d pulses missing, expected 0", q_idx.size()); end
      if (q_slip.size() != 0) begin fails++; $display("FAIL drain_slip: %0d pulses missing, expected 0", q_slip.size()); end
      if (q_lk_t.size() != 0) begin fails++; $display("FAIL drain_locked: %0d changes missing, expected 0", q_lk_t.size()); end
    end
  end

  int t, g, r, horizon;
  int pl[9];

  initial begin
    hall_in = 1'b1;
    rst     = 1'b1;
    // Reset held 5 cycles with a hall pulse inside it.
    repeat (2) @(negedge clk);
    hall_in = 1'b0;
    repeat (2) @(negedge clk);
    hall_in = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    zero_req++;
    repeat (2) @(negedge clk);

    // Lock, glitches, speed changes, then hall stops for timeout.
    @(posedge clk);
    clear_all();
    lim = 32'h7fffffff;
    pl = '{3600, 3600, 3600, 3000, 3000, 3600, 4000, 0, 3600};
    pl[7] = $urandom_range(3900, 3300);
    t = cyc + 50;
    add_ev(t, real_w());
    for (int i = 0; i < 9; i++) begin
      g = (i < 2) ? 100 : $urandom_range(2900, 60);
      add_ev(t + g, glitch_w());
      t += pl[i];
      add_ev(t, real_w());
    end
    model();
    horizon = t + LAT + MAXP + 100;
    drive(32'h7fffffff);
    while (cyc < horizon) @(negedge clk);
    drain_req++;
    repeat (2) @(negedge clk);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    zero_req++;
    repeat (2) @(negedge clk);

    // Reset asserted at tick 100 of a locked revolution.
    @(posedge clk);
    clear_all();
    lim = 32'h7fffffff;
    t = cyc + 50;
    add_ev(t, real_w());
    add_ev(t + 3600, real_w());
    add_ev(t + 7200, real_w());
    model();
    r = q_fan[460];
    q_fan.delete(); q_idx.delete(); q_per.delete(); q_slip.delete();
    q_lk_t.delete(); q_lk_v.delete();
    lim = r;
    model();
    q_lk_t.push_back(r + 1);
    q_lk_v.push_back(1'b0);
    drive(r);
    while (cyc < r) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    zero_req++;
    drain_req++;
    repeat (2) @(negedge clk);

    // Relock after reset needs two fresh indexes.
    @(posedge clk);
    clear_all();
    t = cyc + 50;
    add_ev(t, real_w());
    add_ev(t + 100, glitch_w());
    add_ev(t + 3500, real_w());
    add_ev(t + 7000, real_w());
    horizon = t + 7000 + LAT + 3600;
    lim = horizon;
    model();
    drive(32'h7fffffff);
    while (cyc < horizon) @(negedge clk);
    drain_req++;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
